// File: rtl/alu_sru_pkg.sv
// Shared state and mode encodings for the sequential shift/rotate unit.
package alu_sru_pkg;

  typedef logic [1:0] sru_state_t;

  localparam sru_state_t StIdle = 2'd0;
  localparam sru_state_t StRun  = 2'd1;
  localparam sru_state_t StDone = 2'd2;

  typedef logic [1:0] sru_mode_t;

  // {op_rotate, op_arithmetic}
  localparam sru_mode_t LSH = 2'b00;
  localparam sru_mode_t ASH = 2'b01;
  localparam sru_mode_t RCL = 2'b10;
  localparam sru_mode_t ROT = 2'b11;

endpackage

// File: rtl/alu_sru_step.sv
// Combinational step: shifts/rotates value by k (0..STEP) places; link ends as the last bit out.
module alu_sru_step
  import alu_sru_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned STEP  = 1,
  localparam int unsigned DW   = $clog2(WIDTH),
  localparam int unsigned KW   = DW + 1
) (
  input  logic [WIDTH-1:0] value_i,
  input  logic             link_i,
  input  sru_mode_t        mode_i,
  input  logic             right_i,
  input  logic [KW-1:0]    k_i,
  output logic [WIDTH-1:0] value_o,
  output logic             link_o
);

  logic [WIDTH-1:0] v;
  logic             l;
  logic             fill;

  always_comb begin
    v    = value_i;
    l    = link_i;
    fill = 1'b0;
    for (int i = 0; i < STEP; i++) begin
      if (KW'(i) < k_i) begin
        if (right_i) begin
          case (mode_i)
            ASH:     fill = v[WIDTH-1];
            RCL:     fill = l;
            ROT:     fill = v[0];
            default: fill = 1'b0;
          endcase
          l = v[0];
          v = {fill, v[WIDTH-1:1]};
        end else begin
          case (mode_i)
            RCL:     fill = l;
            ROT:     fill = v[WIDTH-1];
            default: fill = 1'b0;
          endcase
          l = v[WIDTH-1];
          v = {v[WIDTH-2:0], fill};
        end
      end
    end
    value_o = v;
    link_o  = l;
  end

endmodule

// File: rtl/alu_sru_seq.sv
// Sequential shift/rotate unit: loads operand and link, then steps up to STEP bits per clock.
module alu_sru_seq
  import alu_sru_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned STEP  = 1,
  localparam int unsigned DW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             nstart,
  input  logic [WIDTH-1:0] b,
  input  logic             fl,
  input  logic             op_right,
  input  logic             op_rotate,
  input  logic             op_arithmetic,
  input  logic [DW-1:0]    op_dist,
  output logic [WIDTH-1:0] result,
  output logic             flout,
  output logic             nbusy,
  output logic             done
);

  localparam int unsigned KW = DW + 1;
  localparam logic [KW-1:0] StepK = KW'(STEP);

  sru_state_t       state_q, state_d;
  logic [DW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] val_q, val_d;
  logic             link_q, link_d;
  sru_mode_t        mode_q, mode_d;
  logic             right_q, right_d;

  logic [KW-1:0]    k;
  logic [KW-1:0]    cnt_rem;
  logic [WIDTH-1:0] step_val;
  logic             step_link;

  assign k       = ({1'b0, cnt_q} < StepK) ? {1'b0, cnt_q} : StepK;
  assign cnt_rem = {1'b0, cnt_q} - k;

  alu_sru_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_step (
    .value_i (val_q),
    .link_i  (link_q),
    .mode_i  (mode_q),
    .right_i (right_q),
    .k_i     (k),
    .value_o (step_val),
    .link_o  (step_link)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    val_d   = val_q;
    link_d  = link_q;
    mode_d  = mode_q;
    right_d = right_q;
    if (state_q == StRun) begin
      val_d  = step_val;
      link_d = step_link;
      cnt_d  = cnt_rem[DW-1:0];
      if (cnt_rem == '0) begin
        state_d = StDone;
      end
    end else if (!nstart) begin
      val_d   = b;
      link_d  = fl;
      cnt_d   = op_dist;
      mode_d  = {op_rotate, op_arithmetic};
      right_d = op_right;
      state_d = (op_dist == '0) ? StDone : StRun;
    end else if (state_q == StDone) begin
      state_d = StIdle;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      val_q   <= '0;
      link_q  <= 1'b0;
      mode_q  <= LSH;
      right_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      val_q   <= val_d;
      link_q  <= link_d;
      mode_q  <= mode_d;
      right_q <= right_d;
    end
  end

  assign result = val_q;
  assign flout  = link_q;
  assign nbusy  = (state_q != StRun);
  assign done   = (state_q == StDone);

endmodule
